// File: rtl/pipelined_fetch_unit.sv
// Fetch stage: owns the PC, issues 1-cycle imem reads, and buffers {instr, pc} for decode.
// Latency: issue -> instr_valid two cycles later; credit check stalls fetch rather than overflow the buffer.
module pipelined_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_input,
  input  logic        pc_en,
  input  logic        flush,
  output logic [31:0] pc,
  output logic        fetch_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q;
  logic [31:0]   inflight_pc_q;
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [31:0]   pcs_q  [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW:0]   credit;
  logic          pop, push, issue;
  logic          unused_ok;

  assign unused_ok = &{1'b0, pc_input[1:0]};

  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready;
  assign push        = inflight_q & ~flush;

  // Entries already owned or about to be owned, net of the one leaving this cycle.
  assign credit = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign issue  = ~rst & pc_en & ~flush & (credit < (CW+1)'(FIFO_DEPTH));

  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign fetch_stall = pc_en & ~flush & ~issue;
  assign instr_data  = data_q[rd_ptr_q];
  assign instr_pc    = pcs_q[rd_ptr_q];

  always_comb begin
    pc_d = pc_q;
    if (flush || issue) pc_d = {pc_input[31:2], 2'b00};
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      data_q[wr_ptr_q] <= imem_rdata;
      pcs_q[wr_ptr_q]  <= inflight_pc_q;
    end
  end

  // The credit check must make this unreachable.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count_q == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_pipelined_fetch_unit.sv
// Bench for pipelined_fetch_unit: directed table, corner sequences, random traffic vs. a queue model.
module tb_pipelined_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0;
  logic        rst, pc_en, flush, instr_ready;
  logic [31:0] pc_input;
  logic [31:0] pc, imem_addr, instr_data, instr_pc;
  logic [31:0] imem_rdata = 32'h0;
  logic        fetch_stall, imem_req, instr_valid;

  pipelined_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_input(pc_input), .pc_en(pc_en), .flush(flush),
    .pc(pc), .fetch_stall(fetch_stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hDEAD_BEEF;
  endfunction

  // Instruction memory: read data one cycle after the request.
  always @(posedge clk) if (imem_req) imem_rdata <= memf(imem_addr);

  typedef struct {
    logic [31:0] d;
    logic [31:0] p;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mpc;
  bit          infl;
  logic [31:0] infl_pc;
  bit          model_ok = 0;
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic pe, input logic fl,
                       input logic [31:0] pin, input logic rd);
    rst = r; pc_en = pe; flush = fl; pc_input = pin; instr_ready = rd;
    #3;
  endtask

  function automatic bit m_issue();
    int pop = (q.size() > 0 && instr_ready) ? 1 : 0;
    return !rst && pc_en && !flush && (q.size() + int'(infl) - pop < DEPTH);
  endfunction

  task automatic check_model();
    bit iss;
    if (!model_ok) return;
    iss = m_issue();
    chk("pc", pc, mpc);
    chk("imem_addr", imem_addr, mpc);
    chk("imem_req", {31'b0, imem_req}, {31'b0, iss});
    chk("fetch_stall", {31'b0, fetch_stall}, {31'b0, pc_en && !flush && !iss});
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0 && instr_valid) begin
      chk("instr_pc", instr_pc, q[0].p);
      chk("instr_data", instr_data, q[0].d);
    end
  endtask

  task automatic tick();
    bit iss, pop, ni;
    logic [31:0] npc;
    iss = m_issue();
    pop = q.size() > 0 && instr_ready;
    @(posedge clk);
    if (rst) begin
      q.delete(); infl = 0; mpc = RPC; model_ok = 1;
    end else begin
      npc = mpc;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (infl) q.push_back('{d: memf(infl_pc), p: infl_pc});
      end
      ni = iss;
      if (iss) infl_pc = mpc;
      infl = ni;
      if (flush || iss) npc = {pc_input[31:2], 2'b00};
      mpc = npc;
    end
    #1;
  endtask

  task automatic cyc(input logic r, input logic pe, input logic fl,
                     input logic [31:0] pin, input logic rd);
    drive(r, pe, fl, pin, rd);
    check_model();
    tick();
  endtask

  typedef struct {
    logic r, pe, fl;
    logic [31:0] pin;
    logic rd;
    logic e_req;
    logic [31:0] e_addr;
    logic e_valid;
    logic [31:0] e_ipc;
    logic e_stall;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] held;
    int waited;
    // Reset then streaming fetch, jump to an unaligned target.
    vecs[0] = '{1, 1, 0, 32'h4,   1, 0, 32'h0,   0, 32'h0,   1};
    vecs[1] = '{0, 1, 0, 32'h4,   1, 1, 32'h0,   0, 32'h0,   0};
    vecs[2] = '{0, 1, 0, 32'h8,   1, 1, 32'h4,   0, 32'h0,   0};
    vecs[3] = '{0, 1, 0, 32'hC,   1, 1, 32'h8,   1, 32'h0,   0};
    vecs[4] = '{0, 1, 0, 32'h10,  1, 1, 32'hC,   1, 32'h4,   0};
    vecs[5] = '{0, 1, 1, 32'h103, 1, 0, 32'h10,  1, 32'h8,   0};
    vecs[6] = '{0, 1, 0, 32'h104, 1, 1, 32'h100, 0, 32'h0,   0};
    vecs[7] = '{0, 1, 0, 32'h108, 1, 1, 32'h104, 0, 32'h0,   0};
    vecs[8] = '{0, 1, 0, 32'h10C, 1, 1, 32'h108, 1, 32'h100, 0};

    drive(1, 0, 0, 32'h0, 1); tick();
    drive(1, 0, 0, 32'h0, 1); tick();

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].r, vecs[i].pe, vecs[i].fl, vecs[i].pin, vecs[i].rd);
      chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("tbl%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("tbl%0d_stall", i), {31'b0, fetch_stall}, {31'b0, vecs[i].e_stall});
      if (vecs[i].e_valid) chk($sformatf("tbl%0d_ipc", i), instr_pc, vecs[i].e_ipc);
      check_model();
      tick();
    end

    // Decode stalled for 6 cycles: buffer fills, fetch stalls, PC freezes.
    for (int i = 0; i < 6; i++) begin
      held = pc;
      drive(0, 1, 0, mpc + 32'd4, 0);
      check_model();
      if (i >= 2) chk("bp_stall", {31'b0, fetch_stall}, 32'd1);
      tick();
      if (i >= 2) chk("bp_pc_frozen", pc, held);
    end
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, mpc + 32'd4, 1);

    // Flush with buffered entries and a fetch in flight.
    cyc(0, 1, 0, mpc + 32'd4, 0);
    cyc(0, 1, 0, mpc + 32'd4, 0);
    drive(0, 1, 1, 32'h100, 1); check_model(); tick();
    drive(0, 1, 0, mpc + 32'd4, 1);
    chk("flush_valid_drop", {31'b0, instr_valid}, 32'd0);
    check_model(); tick();
    waited = 0;
    while (!instr_valid && waited < 10) begin
      cyc(0, 1, 0, mpc + 32'd4, 1);
      waited++;
    end
    drive(0, 1, 0, mpc + 32'd4, 1);
    chk("flush_first_valid_seen", {31'b0, instr_valid}, 32'd1);
    chk("flush_first_pc", instr_pc, 32'h100);
    check_model(); tick();

    // pc_en low for 3 cycles: no requests, no stall, buffer drains.
    for (int i = 0; i < 3; i++) begin
      held = pc;
      drive(0, 0, 0, 32'hFFF0, 1);
      check_model();
      chk("pcen0_req", {31'b0, imem_req}, 32'd0);
      chk("pcen0_stall", {31'b0, fetch_stall}, 32'd0);
      tick();
      chk("pcen0_pc_held", pc, held);
    end
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, mpc + 32'd4, 1);

    // Reset with a non-empty buffer.
    cyc(0, 1, 0, mpc + 32'd4, 0);
    cyc(0, 1, 0, mpc + 32'd4, 0);
    drive(1, 1, 0, mpc + 32'd4, 1);
    chk("rst_no_req", {31'b0, imem_req}, 32'd0);
    check_model(); tick();
    drive(0, 1, 0, RPC + 32'd4, 1);
    chk("rst_valid_clr", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc", pc, RPC);
    check_model(); tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic r, pe, fl, rd;
      logic [31:0] pin;
      r  = ($urandom_range(0, 99) == 0);
      pe = ($urandom_range(0, 99) < 80);
      fl = ($urandom_range(0, 15) == 0);
      rd = ($urandom_range(0, 99) < 70);
      pin = fl ? ($urandom() & 32'h0000_FFFF) : mpc + 32'd4;
      cyc(r, pe, fl, pin, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
